// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, opcode encodings and the
// legality check used by the arbiter to flag reserved opcodes.
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_GT  = 3'b111;

  // Response register states; the encoding is exactly rsp_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_GT: legal = 1'b1;
      default:                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational shared ALU.
// Ports:
//   aluop_i  - operation code (alu_pkg encodings)
//   ope1_i   - first operand
//   ope2_i   - second operand
//   result_o - result; 0 for reserved opcodes
module alu_arbiter_alu
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [2:0]   aluop_i,
  input  logic [W-1:0] ope1_i,
  input  logic [W-1:0] ope2_i,
  output logic [W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (aluop_i)
      OP_AND:  result_o = ope1_i & ope2_i;
      OP_OR:   result_o = ope1_i | ope2_i;
      OP_ADD:  result_o = ope1_i + ope2_i;
      OP_SUB:  result_o = ope1_i - ope2_i;
      // Unsigned compare, result only in bit 0.
      OP_GT:   result_o = {{(W-1){1'b0}}, (ope1_i > ope2_i)};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a single shared ALU. An accepted
// request is computed in the same cycle and its result lands in a response
// register one cycle later, held until the consumer takes it.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   req_valid / req_ready    - per-requester handshake (bit i = requester i)
//   req0_* / req1_*          - operands and opcode of each requester
//   rsp_valid / rsp_ready    - response handshake
//   rsp_result/rsp_src/rsp_err - registered result, issuing requester, illegal-op flag
//   op_count                 - consumed responses, modulo 2^CNT_W
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [W-1:0]     req0_ope1,
  input  logic [W-1:0]     req0_ope2,
  input  logic [2:0]       req0_aluop,
  input  logic [W-1:0]     req1_ope1,
  input  logic [W-1:0]     req1_ope2,
  input  logic [2:0]       req1_aluop,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_result,
  output logic             rsp_src,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  rsp_state_e       state_q, state_d;
  logic [W-1:0]     result_q, result_d;
  logic             src_q, src_d;
  logic             err_q, err_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [1:0]       grant;
  logic             can_accept;
  logic             handshake;
  logic             sel;
  logic [2:0]       alu_op;
  logic [W-1:0]     alu_a, alu_b, alu_res;

  // Lone requester always wins; on conflict the one not served last wins.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // A held response being consumed this cycle frees the register for a new one.
  assign can_accept = (state_q == ST_EMPTY) | rsp_ready;
  assign req_ready  = rst_n ? (grant & {2{can_accept}}) : 2'b00;
  assign handshake  = |(req_valid & req_ready);
  assign sel        = req_ready[1];

  assign alu_op = sel ? req1_aluop : req0_aluop;
  assign alu_a  = sel ? req1_ope1  : req0_ope1;
  assign alu_b  = sel ? req1_ope2  : req0_ope2;

  alu_arbiter_alu #(.W(W)) u_alu (
    .aluop_i  (alu_op),
    .ope1_i   (alu_a),
    .ope2_i   (alu_b),
    .result_o (alu_res)
  );

  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    src_d        = src_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
      count_d = count_q + CNT_W'(1);
    end
    if (handshake) begin
      state_d      = ST_FULL;
      result_d     = is_legal_op(alu_op) ? alu_res : '0;
      err_d        = ~is_legal_op(alu_op);
      src_d        = sel;
      last_grant_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      result_q     <= '0;
      src_q        <= 1'b0;
      err_q        <= 1'b0;
      last_grant_q <= 1'b1;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      src_q        <= src_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
    end
  end

  assign rsp_valid  = (state_q == ST_FULL);
  assign rsp_result = result_q;
  assign rsp_src    = src_q;
  assign rsp_err    = err_q;
  assign op_count   = count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W     = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [W-1:0]     req0_ope1, req0_ope2, req1_ope1, req1_ope2;
  logic [2:0]       req0_aluop, req1_aluop;
  logic             rsp_valid, rsp_ready;
  logic [W-1:0]     rsp_result;
  logic             rsp_src, rsp_err;
  logic [CNT_W-1:0] op_count;

  typedef struct packed {
    logic [W-1:0] res;
    logic         src;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_ope1  (req0_ope1),
    .req0_ope2  (req0_ope2),
    .req0_aluop (req0_aluop),
    .req1_ope1  (req1_ope1),
    .req1_ope2  (req1_ope2),
    .req1_aluop (req1_aluop),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_src    (rsp_src),
    .rsp_err    (rsp_err),
    .op_count   (op_count)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push(input logic [W-1:0] res, input logic src, input logic err);
    exp_t e;
    e.res = res;
    e.src = src;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic set0(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req0_aluop = op;
    req0_ope1  = a;
    req0_ope2  = b;
  endtask

  task automatic set1(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req1_aluop = op;
    req1_ope1  = a;
    req1_ope2  = b;
  endtask

  // Monitor: every consumed response must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected got result %0h src %0b with no expectation queued",
                   rsp_result, rsp_src);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", 64'(rsp_result), 64'(e.res));
          chk("sb_src", 64'(rsp_src), 64'(e.src));
          chk("sb_err", 64'(rsp_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    set0(OP_AND, '0, '0);
    set1(OP_AND, '0, '0);

    // Reset state
    neg();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_src", 64'(rsp_src), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_req_ready_idle", 64'(req_ready), 64'd0);
    req_valid = 2'b01;
    #1;
    chk("rst_req_ready_valid", 64'(req_ready), 64'd0);
    tick();
    rst_n     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;

    // Single request: ADD 5+7
    tick();
    req_valid = 2'b01;
    set0(OP_ADD, 32'd5, 32'd7);
    neg();
    chk("add_req_ready", 64'(req_ready), 64'h1);
    push(32'd12, 1'b0, 1'b0);
    tick();
    req_valid = 2'b00;
    neg();
    chk("add_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("add_rsp_result", 64'(rsp_result), 64'd12);

    // Illegal opcode on requester 1, then legal OR
    tick();
    req_valid = 2'b10;
    set1(3'b100, 32'hFFFF_FFFF, 32'd1);
    neg();
    chk("ill_req_ready", 64'(req_ready), 64'h2);
    push(32'd0, 1'b1, 1'b1);
    tick();
    set1(OP_OR, 32'h0000_00F0, 32'h0000_000F);
    neg();
    chk("ill_rsp_err", 64'(rsp_err), 64'd1);
    chk("ill_rsp_src", 64'(rsp_src), 64'd1);
    chk("ill_rsp_result", 64'(rsp_result), 64'd0);
    chk("or_req_ready", 64'(req_ready), 64'h2);
    push(32'h0000_00FF, 1'b1, 1'b0);
    tick();
    req_valid = 2'b00;
    neg();
    chk("or_rsp_err", 64'(rsp_err), 64'd0);
    chk("or_rsp_result", 64'(rsp_result), 64'hFF);
    tick();
    neg();
    chk("cnt_after_or", 64'(op_count), 64'd3);

    // Both requesters continuously valid: grants alternate 0,1,0,1
    tick();
    req_valid = 2'b11;
    set0(OP_SUB, 32'd10, 32'd3);
    set1(OP_GT, 32'd9, 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) tick();
      neg();
      if (k % 2 == 0) begin
        chk("rr_grant", 64'(req_ready), 64'h1);
        push(32'd7, 1'b0, 1'b0);
      end else begin
        chk("rr_grant", 64'(req_ready), 64'h2);
        push(32'd1, 1'b1, 1'b0);
      end
    end
    tick();
    req_valid = 2'b00;
    neg();
    tick();
    neg();
    chk("rr_rsp_valid_drained", 64'(rsp_valid), 64'd0);
    chk("cnt_after_rr", 64'(op_count), 64'd7);

    // Back-pressure: GT 80000000 > 7FFFFFFF held while req1 waits
    tick();
    req_valid = 2'b01;
    set0(OP_GT, 32'h8000_0000, 32'h7FFF_FFFF);
    neg();
    chk("gt_req_ready", 64'(req_ready), 64'h1);
    push(32'd1, 1'b0, 1'b0);
    tick();
    rsp_ready = 1'b0;
    req_valid = 2'b10;
    set1(OP_SUB, 32'd0, 32'd1);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) tick();
      neg();
      chk("bp_req_ready", 64'(req_ready), 64'h0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_result", 64'(rsp_result), 64'd1);
      chk("bp_rsp_src", 64'(rsp_src), 64'd0);
    end
    tick();
    rsp_ready = 1'b1;
    neg();
    chk("bp_release_req_ready", 64'(req_ready), 64'h2);
    push(32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    req_valid = 2'b00;
    neg();
    chk("sub_wrap_result", 64'(rsp_result), 64'hFFFF_FFFF);
    chk("sub_wrap_src", 64'(rsp_src), 64'd1);
    tick();
    neg();
    chk("cnt_after_bp", 64'(op_count), 64'd9);

    // ADD wrap FFFFFFFF + 1
    tick();
    req_valid = 2'b01;
    set0(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    neg();
    push(32'd0, 1'b0, 1'b0);
    tick();
    req_valid = 2'b00;
    neg();
    chk("add_wrap_valid", 64'(rsp_valid), 64'd1);
    chk("add_wrap_result", 64'(rsp_result), 64'd0);
    tick();
    neg();
    chk("cnt_after_addwrap", 64'(op_count), 64'd10);

    // Seven back-to-back ANDs bring the count to 17, i.e. 1 modulo 16
    for (int i = 1; i <= 7; i++) begin
      tick();
      req_valid = 2'b01;
      set0(OP_AND, 32'(i * 17), 32'h0000_000F);
      neg();
      chk("and_stream_ready", 64'(req_ready), 64'h1);
      push(32'(i), 1'b0, 1'b0);
    end
    tick();
    req_valid = 2'b00;
    neg();
    tick();
    neg();
    chk("cnt_wrap", 64'(op_count), 64'd1);

    // Reset while a response is held
    tick();
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    set0(OP_AND, 32'd3, 32'd1);
    neg();
    chk("pre_rst_req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    neg();
    chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_op_count", 64'(op_count), 64'd0);
    chk("async_rst_result", 64'(rsp_result), 64'd0);
    chk("async_rst_req_ready", 64'(req_ready), 64'd0);
    tick();
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    set0(OP_OR, 32'd1, 32'd2);
    set1(OP_AND, 32'hFF, 32'h0F);
    neg();
    chk("post_rst_first_grant", 64'(req_ready), 64'h1);
    push(32'd3, 1'b0, 1'b0);
    tick();
    neg();
    chk("post_rst_second_grant", 64'(req_ready), 64'h2);
    push(32'h0F, 1'b1, 1'b0);
    tick();
    req_valid = 2'b00;
    neg();
    tick();
    neg();
    chk("post_rst_drained", 64'(rsp_valid), 64'd0);
    chk("post_rst_op_count", 64'(op_count), 64'd2);
    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters (port 0, port 1) using round-robin arbitration and valid/ready handshakes on both sides.
- Each accepted request drives the ALU for one cycle. The result is captured into a response register held until the consumer accepts it.
- Sits between the instruction-issue logic, where requester 0 is the main datapath and requester 1 is the address/branch unit, and the shared ALU.
- Sustains one operation per cycle when the response side is not stalled.

Parameters:
- W, 32, operand/result width; must match the ALU width.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester request valid; bit i belongs to requester i
- req_ready  output  2  per-requester accept; a handshake occurs when valid[i] & ready[i]
- req0_ope1, req0_ope2  input  W each  requester 0 operands
- req0_aluop  input  3  requester 0 operation code
- req1_ope1, req1_ope2  input  W each  requester 1 operands
- req1_aluop  input  3  requester 1 operation code
- rsp_valid  output  1  response register holds an unconsumed result
- rsp_ready  input  1  consumer accepts the response
- rsp_result  output  W  registered ALU result
- rsp_src  output  1  index of the requester that issued this result
- rsp_err  output  1  issued opcode was illegal
- op_count  output  CNT_W  number of responses consumed; wraps modulo 2^CNT_W

Behaviour:
- Reset, asynchronous with rst_n=0:
  - rsp_valid=0, rsp_result=0, rsp_src=0, rsp_err=0, op_count=0.
  - Internal last_grant=1, so requester 0 wins the first conflict.
  - req_ready=0 while in reset.
  - A reset mid-operation discards any held response with no partial outputs.
- Opcodes:
  - Legal codes: 000 AND, 001 OR, 010 ADD (wraps mod 2^W), 110 SUB (wraps), 111 unsigned greater-than giving 1 or 0 in bit 0, upper bits 0.
  - Illegal codes 011, 100, 101: rsp_result=0 and rsp_err=1. The ALU output is ignored for these codes.
- can_accept = !rsp_valid | rsp_ready. This allows a response to be consumed and a new request issued in the same cycle.
- Arbitration, combinational:
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - req_ready[i] = grant[i] & can_accept. At most one req_ready bit is high.
  - req_ready[i] may depend on req_valid; requesters must not make valid depend on ready.
- Issue:
  - On a handshake, the granted operands and aluop are muxed to the ALU.
  - At the next clock edge: rsp_result/rsp_err/rsp_src are loaded, rsp_valid=1, last_grant=granted index.
  - Latency is 1 cycle from handshake to rsp_valid.
- States are encoded by rsp_valid: EMPTY and FULL.
  - EMPTY + handshake -> FULL.
  - FULL + rsp_ready + handshake -> FULL with the new data.
  - FULL + rsp_ready + no handshake -> EMPTY.
  - FULL + !rsp_ready -> FULL, with rsp_* held stable and req_ready=0.
- op_count increments on each rsp_valid & rsp_ready cycle and wraps from 2^CNT_W-1 to 0.
- Requester rules:
  - Inputs must be held stable while valid is high and not yet accepted.
  - A dropped valid without a handshake is allowed; no state changes.
- Fairness: under continuous double requests, grants alternate 0,1,0,1. No requester waits more than one grant.

Decomposition:
- Shared package alu_pkg holds:
  - The opcode constants OP_AND=000, OP_OR=001, OP_ADD=010, OP_SUB=110, OP_GT=111.
  - An is_legal_op function.
  - The default width W=32.
- Natural sub-module: the existing ALU, instantiated once inside alu_arbiter.
- The arbiter (round-robin grant, 2 bits) stays inline; no second sub-module is needed.

Test Plan:
- Reset with both requesters idle -> all outputs 0, req_ready=00; after release, req0 valid with ADD 5+7 -> req_ready=01, next cycle rsp_valid=1, rsp_result=12, rsp_src=0, rsp_err=0.
- Both valid for 4 cycles, rsp_ready=1: req0 SUB 10-3, req1 GT 9>4 -> grants 0,1,0,1, responses 7(src0), 1(src1), 7, 1; op_count reaches 4.
- Back-pressure: a response is held with rsp_ready=0 for 3 cycles while req1 is valid -> rsp_* stable, req_ready=00; rsp_ready=1 -> req1 accepted in the same cycle, new result the next cycle.
- Illegal opcode 100 on req1 with operands FFFFFFFF, 1 -> rsp_result=0, rsp_err=1, rsp_src=1; a following legal OR 0xF0|0x0F -> 0xFF with rsp_err=0.
- Wrap cases:
  - ADD FFFFFFFF+1 -> 0.
  - SUB 0-1 -> FFFFFFFF.
  - GT 80000000>7FFFFFFF -> 1 (unsigned).
  - With CNT_W=4, 17 consumed responses -> op_count=1.
- Reset mid-operation: assert rst_n=0 while rsp_valid=1 -> rsp_valid drops immediately and asynchronously, op_count=0; after release, simultaneous requests grant requester 0 first.
